// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared dump-state encoding and default parameters for regfile_mp
package regfile_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_NUM_READ   = 3;
  localparam bit DEF_BYPASS     = 1'b1;

  typedef enum logic [0:0] {
    DUMP_IDLE = 1'b0,
    DUMP_RUN  = 1'b1
  } dump_state_t;

endpackage

// File: rtl/regfile_dump_fsm.sv
// rtl/regfile_dump_fsm.sv - sequential register dump stream with a registered per-index snapshot
module regfile_dump_fsm
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dump_start,
  input  logic                  dump_ready,
  output logic                  dump_valid,
  output logic [ADDR_WIDTH-1:0] dump_addr,
  output logic [DATA_WIDTH-1:0] dump_data,
  output logic                  dump_busy,
  output logic                  dump_done,
  output logic [ADDR_WIDTH-1:0] snap_addr,
  input  logic [DATA_WIDTH-1:0] snap_data
);

  localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = '1;

  dump_state_t           state;
  logic [ADDR_WIDTH-1:0] index;

  // snap_addr points at the index being entered, so snap_data is the pre-edge stored value
  assign snap_addr  = (state == DUMP_IDLE) ? '0 : index + 1'b1;
  assign dump_valid = (state == DUMP_RUN);
  assign dump_busy  = (state == DUMP_RUN);
  assign dump_addr  = index;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= DUMP_IDLE;
      index     <= '0;
      dump_data <= '0;
      dump_done <= 1'b0;
    end else begin
      dump_done <= 1'b0;
      case (state)
        DUMP_IDLE: begin
          if (dump_start) begin
            state     <= DUMP_RUN;
            index     <= '0;
            dump_data <= snap_data;
          end
        end
        DUMP_RUN: begin
          if (dump_ready) begin
            if (index == LAST_INDEX) begin
              state     <= DUMP_IDLE;
              dump_done <= 1'b1;
            end else begin
              index     <= snap_addr;
              dump_data <= snap_data;
            end
          end
        end
        default: state <= DUMP_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - dual-write multi-read register file with bypass, pending scoreboard and dump port
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_READ   = DEF_NUM_READ,
  parameter bit BYPASS     = DEF_BYPASS
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 we0,
  input  logic [ADDR_WIDTH-1:0]                waddr0,
  input  logic [DATA_WIDTH-1:0]                wdata0,
  input  logic                                 we1,
  input  logic [ADDR_WIDTH-1:0]                waddr1,
  input  logic [DATA_WIDTH-1:0]                wdata1,
  input  logic [NUM_READ-1:0][ADDR_WIDTH-1:0]  raddr,
  output logic [NUM_READ-1:0][DATA_WIDTH-1:0]  rdata,
  output logic [NUM_READ-1:0]                  rbusy,
  input  logic                                 issue_valid,
  input  logic [ADDR_WIDTH-1:0]                issue_addr,
  input  logic                                 dump_start,
  output logic                                 dump_valid,
  input  logic                                 dump_ready,
  output logic [ADDR_WIDTH-1:0]                dump_addr,
  output logic [DATA_WIDTH-1:0]                dump_data,
  output logic                                 dump_busy,
  output logic                                 dump_done
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   pending;
  logic                  wr0_en;
  logic                  wr1_en;
  logic [ADDR_WIDTH-1:0] snap_addr;
  logic [DATA_WIDTH-1:0] snap_data;

  assign wr0_en = we0 && (waddr0 != '0);
  assign wr1_en = we1 && (waddr1 != '0);

  // port 1 is applied last so it wins a same-address collision; issue wins over clear
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
      pending <= '0;
    end else begin
      if (wr0_en) regs[waddr0] <= wdata0;
      if (wr1_en) begin
        regs[waddr1]    <= wdata1;
        pending[waddr1] <= 1'b0;
      end
      if (issue_valid && (issue_addr != '0)) pending[issue_addr] <= 1'b1;
    end
  end

  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int p = 0; p < NUM_READ; p++) begin
      rdata[p] = regs[raddr[p]];
      rbusy[p] = pending[raddr[p]];
      if (BYPASS && (raddr[p] != '0)) begin
        if (wr0_en && (waddr0 == raddr[p])) rdata[p] = wdata0;
        if (wr1_en && (waddr1 == raddr[p])) rdata[p] = wdata1;
      end
    end
  end

  assign snap_data = regs[snap_addr];

  regfile_dump_fsm #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_dump (
    .clk       (clk),
    .reset     (reset),
    .dump_start(dump_start),
    .dump_ready(dump_ready),
    .dump_valid(dump_valid),
    .dump_addr (dump_addr),
    .dump_data (dump_data),
    .dump_busy (dump_busy),
    .dump_done (dump_done),
    .snap_addr (snap_addr),
    .snap_data (snap_data)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed self-checking bench for regfile_mp
module tb_regfile_mp;

  logic              clk = 1'b0;
  logic              reset;
  logic              we0, we1;
  logic [4:0]        waddr0, waddr1;
  logic [31:0]       wdata0, wdata1;
  logic [2:0][4:0]   raddr;
  logic [2:0][31:0]  rdata;
  logic [2:0]        rbusy;
  logic              issue_valid;
  logic [4:0]        issue_addr;
  logic              dump_start, dump_valid, dump_ready, dump_busy, dump_done;
  logic [4:0]        dump_addr;
  logic [31:0]       dump_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_mp dut (
    .clk(clk), .reset(reset),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_addr(dump_addr), .dump_data(dump_data),
    .dump_busy(dump_busy), .dump_done(dump_done)
  );

  task automatic idle_inputs();
    we0 = 1'b0; waddr0 = '0; wdata0 = '0;
    we1 = 1'b0; waddr1 = '0; wdata1 = '0;
    issue_valid = 1'b0; issue_addr = '0;
    dump_start = 1'b0;
  endtask

  // inputs change just after a falling edge; outputs are sampled there too
  task automatic next();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    dump_ready = 1'b0;
    raddr = {5'd3, 5'd2, 5'd1};
    next();
    next();
    #1;
    checks++; if (rdata !== '0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    checks++; if (rbusy !== 3'b000) begin errors++; $display("FAIL reset_rbusy got=%b exp=000", rbusy); end
    checks++; if ({dump_valid, dump_busy, dump_done} !== 3'b000) begin
      errors++; $display("FAIL reset_dump got=%b exp=000", {dump_valid, dump_busy, dump_done});
    end
    reset = 1'b1;
    next();
  endtask

  task automatic test_bypass();
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
    raddr[0] = 5'd5; raddr[1] = 5'd4;
    #1;
    checks++; if (rdata[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_same_cycle got=%h exp=deadbeef", rdata[0]); end
    checks++; if (rdata[1] !== 32'h0) begin errors++; $display("FAIL bypass_other_addr got=%h exp=0", rdata[1]); end
    next();
    idle_inputs();
    #1;
    checks++; if (rdata[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_stored got=%h exp=deadbeef", rdata[0]); end
    we0 = 1'b1; waddr0 = 5'd6; wdata0 = 32'h1;
    we1 = 1'b1; waddr1 = 5'd6; wdata1 = 32'h2;
    raddr[1] = 5'd6;
    #1;
    checks++; if (rdata[1] !== 32'h2) begin errors++; $display("FAIL bypass_port1_prio got=%h exp=2", rdata[1]); end
    next();
    idle_inputs();
  endtask

  task automatic test_same_addr();
    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11;
    we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22;
    next();
    idle_inputs();
    raddr[0] = 5'd7;
    #1;
    checks++; if (rdata[0] !== 32'h22) begin errors++; $display("FAIL same_addr_x7 got=%h exp=22", rdata[0]); end
    we0 = 1'b1; waddr0 = 5'd10; wdata0 = 32'hA0;
    we1 = 1'b1; waddr1 = 5'd11; wdata1 = 32'hB1;
    next();
    idle_inputs();
    raddr[0] = 5'd10; raddr[1] = 5'd11;
    #1;
    checks++; if (rdata[0] !== 32'hA0) begin errors++; $display("FAIL dual_write_x10 got=%h exp=a0", rdata[0]); end
    checks++; if (rdata[1] !== 32'hB1) begin errors++; $display("FAIL dual_write_x11 got=%h exp=b1", rdata[1]); end
  endtask

  task automatic test_pending();
    issue_valid = 1'b1; issue_addr = 5'd9; raddr[2] = 5'd9;
    #1;
    checks++; if (rbusy[2] !== 1'b0) begin errors++; $display("FAIL pend_no_fwd got=%b exp=0", rbusy[2]); end
    next();
    idle_inputs();
    #1;
    checks++; if (rbusy[2] !== 1'b1) begin errors++; $display("FAIL pend_set got=%b exp=1", rbusy[2]); end
    we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h77;
    next();
    idle_inputs();
    #1;
    checks++; if (rbusy[2] !== 1'b1) begin errors++; $display("FAIL pend_we0_keeps got=%b exp=1", rbusy[2]); end
    we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h55;
    #1;
    checks++; if (rbusy[2] !== 1'b1) begin errors++; $display("FAIL pend_during_wb got=%b exp=1", rbusy[2]); end
    next();
    idle_inputs();
    #1;
    checks++; if (rbusy[2] !== 1'b0) begin errors++; $display("FAIL pend_cleared got=%b exp=0", rbusy[2]); end
    checks++; if (rdata[2] !== 32'h55) begin errors++; $display("FAIL pend_wb_data got=%h exp=55", rdata[2]); end
    issue_valid = 1'b1; issue_addr = 5'd9;
    we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h66;
    next();
    idle_inputs();
    #1;
    checks++; if (rbusy[2] !== 1'b1) begin errors++; $display("FAIL pend_set_wins got=%b exp=1", rbusy[2]); end
    we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h67;
    next();
    idle_inputs();
  endtask

  task automatic test_x0();
    we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFFFFFF;
    we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFFFFFF;
    issue_valid = 1'b1; issue_addr = 5'd0;
    raddr[0] = 5'd0;
    #1;
    checks++; if (rdata[0] !== 32'h0) begin errors++; $display("FAIL x0_no_bypass got=%h exp=0", rdata[0]); end
    next();
    idle_inputs();
    #1;
    checks++; if (rdata[0] !== 32'h0) begin errors++; $display("FAIL x0_stored got=%h exp=0", rdata[0]); end
    checks++; if (rbusy[0] !== 1'b0) begin errors++; $display("FAIL x0_pending got=%b exp=0", rbusy[0]); end
  endtask

  task automatic test_dump();
    int exp_idx = 0;
    int transfers = 0;
    int dones = 0;
    int busy_bad = 0;
    bit wrote = 1'b0;
    logic [31:0] exp_data;
    for (int i = 1; i < 32; i++) begin
      we0 = 1'b1; waddr0 = i[4:0]; wdata0 = 32'h100 + i;
      next();
    end
    idle_inputs();
    raddr[0] = 5'd3;
    dump_start = 1'b1;
    next();
    dump_start = 1'b0;
    #1;
    checks++; if ({dump_valid, dump_busy, dump_addr} !== {2'b11, 5'd0}) begin
      errors++; $display("FAIL dump_first got=%b/%b/%0d exp=1/1/0", dump_valid, dump_busy, dump_addr);
    end
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (transfers == 32) break;
      if (dump_done) dones++;
      if (dump_busy !== dump_valid) busy_bad++;
      dump_ready = cyc[0];
      we1 = 1'b0;
      if (dump_valid && dump_addr == 5'd3 && !dump_ready && !wrote) begin
        we1 = 1'b1; waddr1 = 5'd3; wdata1 = 32'hCAFE; wrote = 1'b1;
      end
      dump_start = dump_valid && dump_addr == 5'd5;
      if (dump_valid && dump_ready) begin
        exp_data = (exp_idx == 0) ? 32'h0 : 32'h100 + exp_idx;
        checks++;
        if (dump_addr !== exp_idx[4:0] || dump_data !== exp_data) begin
          errors++;
          $display("FAIL dump_xfer got=%0d:%h exp=%0d:%h", dump_addr, dump_data, exp_idx, exp_data);
        end
        exp_idx++;
        transfers++;
      end
      next();
    end
    idle_inputs();
    dump_ready = 1'b0;
    #1;
    if (dump_done) dones++;
    checks++; if (transfers != 32) begin errors++; $display("FAIL dump_count got=%0d exp=32", transfers); end
    checks++; if (dump_valid !== 1'b0) begin errors++; $display("FAIL dump_end_valid got=%b exp=0", dump_valid); end
    checks++; if (dump_done !== 1'b1) begin errors++; $display("FAIL dump_done_pulse got=%b exp=1", dump_done); end
    next();
    #1;
    if (dump_done) dones++;
    checks++; if (dones != 1) begin errors++; $display("FAIL dump_done_count got=%0d exp=1", dones); end
    checks++; if (busy_bad != 0) begin errors++; $display("FAIL dump_busy_eq got=%0d exp=0", busy_bad); end
    checks++; if (rdata[0] !== 32'hCAFE) begin errors++; $display("FAIL dump_concurrent_wr got=%h exp=cafe", rdata[0]); end
  endtask

  task automatic test_reset_mid_dump();
    bit found = 1'b0;
    int dones = 0;
    issue_valid = 1'b1; issue_addr = 5'd12;
    next();
    idle_inputs();
    dump_ready = 1'b1;
    dump_start = 1'b1;
    next();
    dump_start = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (dump_valid && dump_addr == 5'd10) begin
        found = 1'b1;
        break;
      end
      next();
    end
    checks++; if (!found) begin errors++; $display("FAIL rst_dump_reach10 got=0 exp=1"); end
    reset = 1'b0;
    next();
    reset = 1'b1;
    raddr = {5'd31, 5'd12, 5'd5};
    #1;
    if (dump_done) dones++;
    checks++; if ({dump_valid, dump_busy} !== 2'b00) begin
      errors++; $display("FAIL rst_dump_abort got=%b exp=00", {dump_valid, dump_busy});
    end
    checks++; if (rdata !== '0) begin errors++; $display("FAIL rst_dump_rdata got=%h exp=0", rdata); end
    checks++; if (rbusy !== 3'b000) begin errors++; $display("FAIL rst_dump_rbusy got=%b exp=000", rbusy); end
    for (int cyc = 0; cyc < 40; cyc++) begin
      next();
      if (dump_done) dones++;
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL rst_dump_no_done got=%0d exp=0", dones); end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_same_addr();
    test_pending();
    test_x0();
    test_dump();
    test_reset_mid_dump();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of each register and every data port.
REQ-002 Parameter ADDR_WIDTH, default 5: register index width; NUM_REGS = 2**ADDR_WIDTH.
REQ-003 Parameter NUM_READ, default 3: number of independent read ports.
REQ-004 Parameter BYPASS, default 1: 1 = same-cycle write-to-read forwarding; 0 = reads return stored values only.
REQ-005 Reset is synchronous and active-low; the clock port is clk and the reset port is reset.
REQ-006 clk  in  1  clock; all state updates on the rising edge.
REQ-007 reset  in  1  synchronous active-low reset.
REQ-008 we0 / waddr0 / wdata0  in  1 / ADDR_WIDTH / DATA_WIDTH  write port 0 (pipeline writeback).
REQ-009 we1 / waddr1 / wdata1  in  1 / ADDR_WIDTH / DATA_WIDTH  write port 1 (long-latency unit writeback).
REQ-010 raddr  in  NUM_READ x ADDR_WIDTH  read addresses.
REQ-011 rdata  out  NUM_READ x DATA_WIDTH  combinational read data.
REQ-012 rbusy  out  NUM_READ  pending-bit of the register addressed by each read port.
REQ-013 issue_valid / issue_addr  in  1 / ADDR_WIDTH  marks a register pending for a long-latency result.
REQ-014 dump_start  in  1  request a sequential dump of all registers.
REQ-015 dump_valid / dump_ready  out / in  1 / 1  dump stream handshake.
REQ-016 dump_addr / dump_data  out  ADDR_WIDTH / DATA_WIDTH  index and snapshot value of the dumped register.
REQ-017 dump_busy / dump_done  out  1 / 1  dump in progress; one-cycle pulse after last transfer.

Function
REQ-018 Register 0 SHALL always read zero, ignore writes, and never be pending.
REQ-019 Register write latency SHALL be one cycle; we0 and we1 to different addresses SHALL both commit.
REQ-020 we0 and we1 to the same nonzero address in one cycle: port 1 data SHALL commit.
REQ-021 BYPASS=1: rdata SHALL return the same-cycle write data (port 1 priority) for a matching nonzero address; otherwise the stored value.
REQ-022 issue_valid SHALL set pending[issue_addr]; a we1 write SHALL clear pending[waddr1]; set wins when both hit the same address in one cycle.
REQ-023 we0 SHALL not alter pending bits; rbusy SHALL reflect the registered pending bits (no forwarding).
REQ-024 Dump FSM states IDLE, RUN; IDLE + dump_start -> RUN with index 0; dump_start in RUN SHALL be ignored.
REQ-025 In RUN dump_valid SHALL be 1 and dump_addr = index; dump_data SHALL be a registered snapshot loaded on entry to each index.
REQ-026 The snapshot SHALL be the stored value before any write committing on the same edge; later writes SHALL not alter a stalled dump_data.
REQ-027 On dump_valid & dump_ready the index SHALL advance; at index NUM_REGS-1 the FSM SHALL return to IDLE and pulse dump_done for one cycle.
REQ-028 dump_busy SHALL equal (state == RUN); first dump_valid SHALL appear the cycle after dump_start.
REQ-029 Register writes and reads SHALL continue unaffected during a dump.

Reset
REQ-030 reset low at a rising edge SHALL clear all registers, all pending bits, index, dump_data, and force IDLE.
REQ-031 After reset: rdata = 0, rbusy = 0, dump_valid = 0, dump_busy = 0, dump_done = 0; reset mid-dump SHALL abort without dump_done.

Structure
REQ-032 Package regfile_pkg SHALL hold the dump state enum and default parameter constants.
REQ-033 The dump FSM and snapshot register SHALL be a sub-module regfile_dump_fsm; storage, decode, bypass and scoreboard stay in regfile_mp.

Verification
REQ-034 we0 x5=0xDEADBEEF, raddr0=5 same cycle -> rdata0=0xDEADBEEF (BYPASS=1); stored value thereafter.
REQ-035 we0 x7=0x11, we1 x7=0x22 same cycle -> x7 reads 0x22.
REQ-036 issue x9, later we1 x9=0x55 -> rbusy high until edge of write, then 0; simultaneous issue+we1 x9 -> stays pending.
REQ-037 write x0=0xFFFFFFFF, issue x0 -> x0 reads 0, rbusy 0.
REQ-038 Dump with dump_ready toggling every other cycle, x3 written mid-stall -> 32 transfers, addr 0..31, stalled snapshot unchanged, one dump_done.
REQ-039 reset low at dump index 10 -> dump_valid 0 next cycle, no dump_done, all registers read 0.
